// File: rtl/ret_fsm_pkg.sv
// ----------------------------------------------------------------------------
// ret_fsm_pkg
// Shared definitions for the return sequencer (and the call sequencer, which
// reuses NOP): widths, FSM state encoding, the injected micro-instruction
// encodings and the word-routing helper that maps a popped word to its
// destination register.
// ----------------------------------------------------------------------------
package ret_fsm_pkg;

    localparam int INSTR_W = 16;   // instruction / stack-word width
    localparam int PC_W    = 32;   // two stack words
    localparam int CCR_W   = 5;    // flag register width

    // Injected micro-instructions, in the opcode map the CU decodes.
    localparam logic [INSTR_W-1:0] NOP       = 16'h0000;
    localparam logic [INSTR_W-1:0] POP_CCR   = 16'h7801;
    localparam logic [INSTR_W-1:0] POP_PC_LO = 16'h7802;
    localparam logic [INSTR_W-1:0] POP_PC_HI = 16'h7803;

    // Number of stack words each return flavour pops.
    localparam logic [1:0] RET_WORDS = 2'd2;
    localparam logic [1:0] RTI_WORDS = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE_CCR = 3'd1,
        ST_ISSUE_LO  = 3'd2,
        ST_ISSUE_HI  = 3'd3,
        ST_WAIT      = 3'd4,
        ST_LOAD      = 3'd5
    } state_e;

    // Destination of a popped word.
    typedef enum logic [1:0] {
        SLOT_CCR = 2'd0,
        SLOT_LO  = 2'd1,
        SLOT_HI  = 2'd2
    } slot_e;

    // Pops leave in stack order CCR, PC_LO, PC_HI. A plain RET has no CCR on
    // the stack, so its word index is shifted up by one slot.
    function automatic slot_e route_word(input logic rti_mode, input logic [1:0] idx);
        logic [1:0] pos;
        pos = rti_mode ? idx : idx + 2'd1;
        case (pos)
            2'd0:    return SLOT_CCR;
            2'd1:    return SLOT_LO;
            default: return SLOT_HI;
        endcase
    endfunction

    // Instruction presented to the FD mux while in a given state.
    function automatic logic [INSTR_W-1:0] inject_for(input state_e s);
        case (s)
            ST_ISSUE_CCR: return POP_CCR;
            ST_ISSUE_LO:  return POP_PC_LO;
            ST_ISSUE_HI:  return POP_PC_HI;
            default:      return NOP;
        endcase
    endfunction

endpackage

// File: rtl/ret_fsm.sv
// ----------------------------------------------------------------------------
// ret_fsm
// Return sequencer. On RET (or RTI) it stalls fetch, injects the pop
// micro-instructions into the fetch/decode path, collects the popped words as
// they complete in the memory stage, and pulses a PC (and for RTI a CCR) load.
//
// Ports
//   clk            clock
//   reset          synchronous, active-high
//   ret, rti       decode-stage RET / RTI pulses (rti wins if both)
//   mem_valid      one injected pop completed in the memory stage
//   mem_data       popped word, valid with mem_valid
//   out            injected instruction for the FD mux (NOP when idle)
//   stall          select out over the fetched word, hold PC increment
//   pc             assembled return PC {PC_HI, PC_LO}
//   change_pc_ret  one-cycle PC load strobe
//   ccr            popped flags (RTI)
//   write_ccr_ret  one-cycle CCR load strobe (RTI only)
//
// All outputs are decoded from registered state only; no input reaches an
// output combinationally.
// ----------------------------------------------------------------------------
module ret_fsm
    import ret_fsm_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               ret,
    input  logic               rti,
    input  logic               mem_valid,
    input  logic [INSTR_W-1:0] mem_data,
    output logic [INSTR_W-1:0] out,
    output logic               stall,
    output logic [PC_W-1:0]    pc,
    output logic               change_pc_ret,
    output logic [CCR_W-1:0]   ccr,
    output logic               write_ccr_ret
);

    state_e             state_q, state_d;
    logic [1:0]         cnt_q, cnt_d;        // words received this sequence
    logic [1:0]         exp_q, exp_d;        // words expected this sequence
    logic               mode_rti_q, mode_rti_d;
    logic [INSTR_W-1:0] pc_lo_q, pc_lo_d;
    logic [INSTR_W-1:0] pc_hi_q, pc_hi_d;
    logic [CCR_W-1:0]   ccr_q, ccr_d;
    logic               accept;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its peers; blocking here would create order-
    // dependent simulation that does not match the synthesized hardware.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 2'd0;
            exp_q      <= 2'd0;
            mode_rti_q <= 1'b0;
            pc_lo_q    <= '0;
            pc_hi_q    <= '0;
            ccr_q      <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            exp_q      <= exp_d;
            mode_rti_q <= mode_rti_d;
            pc_lo_q    <= pc_lo_d;
            pc_hi_q    <= pc_hi_d;
            ccr_q      <= ccr_d;
        end
    end

    // NOTE: every signal written here gets a hold-value default first, so no
    // path through the case statements can leave one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        exp_d      = exp_q;
        mode_rti_d = mode_rti_q;
        pc_lo_d    = pc_lo_q;
        pc_hi_d    = pc_hi_q;
        ccr_d      = ccr_q;

        // A word counts only while a sequence is active and still short of
        // its expected count; anything else is dropped without side effects.
        accept = (state_q != ST_IDLE) && mem_valid && (cnt_q != exp_q);

        if (accept) begin
            cnt_d = cnt_q + 2'd1;
            case (route_word(mode_rti_q, cnt_q))
                SLOT_CCR: ccr_d   = mem_data[CCR_W-1:0];
                SLOT_LO:  pc_lo_d = mem_data;
                default:  pc_hi_d = mem_data;
            endcase
        end

        case (state_q)
            ST_IDLE: begin
                cnt_d = 2'd0;
                if (rti) begin
                    state_d    = ST_ISSUE_CCR;
                    mode_rti_d = 1'b1;
                    exp_d      = RTI_WORDS;
                end else if (ret) begin
                    state_d    = ST_ISSUE_LO;
                    mode_rti_d = 1'b0;
                    exp_d      = RET_WORDS;
                end
            end
            ST_ISSUE_CCR: state_d = ST_ISSUE_LO;
            ST_ISSUE_LO:  state_d = ST_ISSUE_HI;
            ST_ISSUE_HI:  state_d = ST_WAIT;
            ST_WAIT: begin
                // cnt_d already includes a word accepted on this edge.
                if (cnt_d == exp_q) state_d = ST_LOAD;
            end
            ST_LOAD:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign out           = inject_for(state_q);
    assign stall         = (state_q != ST_IDLE);
    assign change_pc_ret = (state_q == ST_LOAD);
    assign write_ccr_ret = (state_q == ST_LOAD) && mode_rti_q;
    assign pc            = {pc_hi_q, pc_lo_q};
    assign ccr           = ccr_q;

endmodule
